// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite response/protection constants and the command-master state encoding.
package axi_lite_pkg;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    localparam logic [2:0] AXI_PROT_DEFAULT = 3'b000;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_WR_AW_W = 3'd1;
    localparam state_t ST_WR_B    = 3'd2;
    localparam state_t ST_RD_AR   = 3'd3;
    localparam state_t ST_RD_R    = 3'd4;
    localparam state_t ST_RSP     = 3'd5;

endpackage

// File: rtl/axi_lite_cmd_master.sv
// Single-outstanding AXI4-Lite master driven by a valid/ready command stream.
// Define AXI_MASTER_TIMEOUT_EN to abort hung bus transactions after TIMEOUT_CYCLES.
module axi_lite_cmd_master
    import axi_lite_pkg::*;
#(
    parameter int ADDR_WIDTH     = 4,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]              rsp_resp,
    output logic                    rsp_timeout,
    output logic [ADDR_WIDTH-1:0]   M_AXI_AWADDR,
    output logic [2:0]              M_AXI_AWPROT,
    output logic                    M_AXI_AWVALID,
    input  logic                    M_AXI_AWREADY,
    output logic [DATA_WIDTH-1:0]   M_AXI_WDATA,
    output logic [DATA_WIDTH/8-1:0] M_AXI_WSTRB,
    output logic                    M_AXI_WVALID,
    input  logic                    M_AXI_WREADY,
    input  logic [1:0]              M_AXI_BRESP,
    input  logic                    M_AXI_BVALID,
    output logic                    M_AXI_BREADY,
    output logic [ADDR_WIDTH-1:0]   M_AXI_ARADDR,
    output logic [2:0]              M_AXI_ARPROT,
    output logic                    M_AXI_ARVALID,
    input  logic                    M_AXI_ARREADY,
    input  logic [DATA_WIDTH-1:0]   M_AXI_RDATA,
    input  logic [1:0]              M_AXI_RRESP,
    input  logic                    M_AXI_RVALID,
    output logic                    M_AXI_RREADY
);

    localparam int STRB_W = DATA_WIDTH / 8;

    state_t                  state_q, state_d;
    logic                    cmd_ready_q, cmd_ready_d;
    logic                    awvalid_q, awvalid_d, wvalid_q, wvalid_d, arvalid_q, arvalid_d;
    logic                    bready_q, bready_d, rready_q, rready_d;
    logic                    aw_done_q, aw_done_d, w_done_q, w_done_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]       wstrb_q, wstrb_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic [1:0]              rsp_resp_q, rsp_resp_d;
    logic                    rsp_timeout_q, rsp_timeout_d;
    logic                    aw_hs, w_hs;

    assign aw_hs = awvalid_q & M_AXI_AWREADY;
    assign w_hs  = wvalid_q & M_AXI_WREADY;

`ifdef AXI_MASTER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 2);

    logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
`else
    logic unused_tmo_param;
    assign unused_tmo_param = (TIMEOUT_CYCLES < 2);
`endif

    always_comb begin
        state_d       = state_q;
        awvalid_d     = awvalid_q;
        wvalid_d      = wvalid_q;
        arvalid_d     = arvalid_q;
        bready_d      = bready_q;
        rready_d      = rready_q;
        aw_done_d     = aw_done_q;
        w_done_d      = w_done_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        wstrb_d       = wstrb_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_resp_d    = rsp_resp_q;
        rsp_timeout_d = rsp_timeout_q;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    addr_d  = cmd_addr;
                    wdata_d = cmd_wdata;
                    wstrb_d = cmd_wstrb;
                    if (cmd_write) begin
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        aw_done_d = 1'b0;
                        w_done_d  = 1'b0;
                        state_d   = ST_WR_AW_W;
                    end else begin
                        arvalid_d = 1'b1;
                        state_d   = ST_RD_AR;
                    end
                end
            end
            ST_WR_AW_W: begin
                // AW and W complete independently; move on once both have handshaken.
                if (aw_hs) begin
                    awvalid_d = 1'b0;
                    aw_done_d = 1'b1;
                end
                if (w_hs) begin
                    wvalid_d = 1'b0;
                    w_done_d = 1'b1;
                end
                if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
                    bready_d = 1'b1;
                    state_d  = ST_WR_B;
                end
            end
            ST_WR_B: begin
                if (M_AXI_BVALID && bready_q) begin
                    bready_d      = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = '0;
                    rsp_resp_d    = M_AXI_BRESP;
                    rsp_timeout_d = 1'b0;
                    state_d       = ST_RSP;
                end
            end
            ST_RD_AR: begin
                if (arvalid_q && M_AXI_ARREADY) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = ST_RD_R;
                end
            end
            ST_RD_R: begin
                if (M_AXI_RVALID && rready_q) begin
                    rready_d      = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = M_AXI_RDATA;
                    rsp_resp_d    = M_AXI_RRESP;
                    rsp_timeout_d = 1'b0;
                    state_d       = ST_RSP;
                end
            end
            ST_RSP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

`ifdef AXI_MASTER_TIMEOUT_EN
        // The abort overrides any slave handshake landing in the same cycle.
        tmo_cnt_d = tmo_cnt_q;
        if (state_q == ST_IDLE) begin
            tmo_cnt_d = '0;
        end else if (state_q != ST_RSP) begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
            if (tmo_cnt_q == TMO_LAST) begin
                awvalid_d     = 1'b0;
                wvalid_d      = 1'b0;
                arvalid_d     = 1'b0;
                bready_d      = 1'b0;
                rready_d      = 1'b0;
                rsp_valid_d   = 1'b1;
                rsp_rdata_d   = '0;
                rsp_resp_d    = AXI_RESP_DECERR;
                rsp_timeout_d = 1'b1;
                state_d       = ST_RSP;
            end
        end
`endif

        cmd_ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            cmd_ready_q   <= 1'b0;
            awvalid_q     <= 1'b0;
            wvalid_q      <= 1'b0;
            arvalid_q     <= 1'b0;
            bready_q      <= 1'b0;
            rready_q      <= 1'b0;
            aw_done_q     <= 1'b0;
            w_done_q      <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_resp_q    <= AXI_RESP_OKAY;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cmd_ready_q   <= cmd_ready_d;
            awvalid_q     <= awvalid_d;
            wvalid_q      <= wvalid_d;
            arvalid_q     <= arvalid_d;
            bready_q      <= bready_d;
            rready_q      <= rready_d;
            aw_done_q     <= aw_done_d;
            w_done_q      <= w_done_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            wstrb_q       <= wstrb_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_resp_q    <= rsp_resp_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

`ifdef AXI_MASTER_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end

    assign rsp_timeout = rsp_timeout_q;
`else
    logic unused_tmo_flag;
    assign unused_tmo_flag = rsp_timeout_q;
    assign rsp_timeout     = 1'b0;
`endif

    assign cmd_ready     = cmd_ready_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_rdata     = rsp_rdata_q;
    assign rsp_resp      = rsp_resp_q;
    assign M_AXI_AWADDR  = addr_q;
    assign M_AXI_AWPROT  = AXI_PROT_DEFAULT;
    assign M_AXI_AWVALID = awvalid_q;
    assign M_AXI_WDATA   = wdata_q;
    assign M_AXI_WSTRB   = wstrb_q;
    assign M_AXI_WVALID  = wvalid_q;
    assign M_AXI_BREADY  = bready_q;
    assign M_AXI_ARADDR  = addr_q;
    assign M_AXI_ARPROT  = AXI_PROT_DEFAULT;
    assign M_AXI_ARVALID = arvalid_q;
    assign M_AXI_RREADY  = rready_q;

endmodule

// File: tb/tb_axi_lite_cmd_master.sv
// Self-checking bench: randomized commands against a configurable-latency AXI4-Lite slave
// and a word-array reference model of the slave address space.
`timescale 1ns/1ps
module tb_axi_lite_cmd_master;

    localparam int AW  = 4;
    localparam int DW  = 32;
    localparam int SW  = DW / 8;
    localparam int TMO = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic [SW-1:0] cmd_wstrb;
    logic          rsp_valid, rsp_ready, rsp_timeout;
    logic [DW-1:0] rsp_rdata;
    logic [1:0]    rsp_resp;
    logic [AW-1:0] AWADDR, ARADDR;
    logic [2:0]    AWPROT, ARPROT;
    logic          AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
    logic          ARVALID, ARREADY, RVALID, RREADY;
    logic [DW-1:0] WDATA, RDATA;
    logic [SW-1:0] WSTRB;
    logic [1:0]    BRESP, RRESP;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    axi_lite_cmd_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
        .M_AXI_AWADDR(AWADDR), .M_AXI_AWPROT(AWPROT), .M_AXI_AWVALID(AWVALID), .M_AXI_AWREADY(AWREADY),
        .M_AXI_WDATA(WDATA), .M_AXI_WSTRB(WSTRB), .M_AXI_WVALID(WVALID), .M_AXI_WREADY(WREADY),
        .M_AXI_BRESP(BRESP), .M_AXI_BVALID(BVALID), .M_AXI_BREADY(BREADY),
        .M_AXI_ARADDR(ARADDR), .M_AXI_ARPROT(ARPROT), .M_AXI_ARVALID(ARVALID), .M_AXI_ARREADY(ARREADY),
        .M_AXI_RDATA(RDATA), .M_AXI_RRESP(RRESP), .M_AXI_RVALID(RVALID), .M_AXI_RREADY(RREADY)
    );

    // ---------------- slave with per-channel wait knobs ----------------
    int          aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
    bit          b_never = 0, force_en = 0;
    logic [1:0]  force_resp = 2'b00;
    logic [DW-1:0] smem [4];
    logic        aw_seen, w_seen, ar_seen;
    logic [AW-1:0] aw_addr_s, ar_addr_s;
    logic [DW-1:0] w_data_s;
    logic [SW-1:0] w_strb_s;
    int          aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;

    function automatic logic [1:0] slave_resp(input logic [AW-1:0] a);
        if (force_en) return force_resp;
        return (a[3:2] == 2'b11) ? 2'b10 : 2'b00;
    endfunction

    assign AWREADY = AWVALID && !aw_seen && (aw_cnt >= aw_dly);
    assign WREADY  = WVALID && !w_seen && (w_cnt >= w_dly);
    assign BVALID  = aw_seen && w_seen && !b_never && (b_cnt >= b_dly);
    assign BRESP   = slave_resp(aw_addr_s);
    assign ARREADY = ARVALID && !ar_seen && (ar_cnt >= ar_dly);
    assign RVALID  = ar_seen && (r_cnt >= r_dly);
    assign RDATA   = RVALID ? smem[ar_addr_s[3:2]] : 32'hDEAD_BEEF;
    assign RRESP   = RVALID ? slave_resp(ar_addr_s) : 2'b01;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_seen <= 0; w_seen <= 0; ar_seen <= 0;
            aw_cnt <= 0; w_cnt <= 0; b_cnt <= 0; ar_cnt <= 0; r_cnt <= 0;
            aw_addr_s <= '0; ar_addr_s <= '0; w_data_s <= '0; w_strb_s <= '0;
            for (int i = 0; i < 4; i++) smem[i] <= '0;
        end else begin
            if (AWVALID && AWREADY) begin aw_seen <= 1; aw_addr_s <= AWADDR; aw_cnt <= 0; end
            else if (AWVALID) aw_cnt <= aw_cnt + 1;
            if (WVALID && WREADY) begin w_seen <= 1; w_data_s <= WDATA; w_strb_s <= WSTRB; w_cnt <= 0; end
            else if (WVALID) w_cnt <= w_cnt + 1;
            if (BVALID && BREADY) begin
                for (int b = 0; b < SW; b++)
                    if (w_strb_s[b]) smem[aw_addr_s[3:2]][8*b +: 8] <= w_data_s[8*b +: 8];
                aw_seen <= 0; w_seen <= 0; b_cnt <= 0;
            end else if (aw_seen && w_seen) b_cnt <= b_cnt + 1;
            if (ARVALID && ARREADY) begin ar_seen <= 1; ar_addr_s <= ARADDR; ar_cnt <= 0; end
            else if (ARVALID) ar_cnt <= ar_cnt + 1;
            if (RVALID && RREADY) begin ar_seen <= 0; r_cnt <= 0; end
            else if (ar_seen) r_cnt <= r_cnt + 1;
        end
    end

    // ---------------- AXI VALID-stability monitor ----------------
    bit   mon_en = 1;
    int   proto_err = 0;
    logic p_aw = 0, p_w = 0, p_ar = 0;
    logic [AW-1:0] p_awaddr = '0, p_araddr = '0;
    always @(posedge clk) begin
        if (!rst_n) begin
            p_aw <= 0; p_w <= 0; p_ar <= 0;
        end else begin
            if (mon_en) begin
                if (p_aw && (!AWVALID || AWADDR !== p_awaddr)) proto_err++;
                if (p_w && !WVALID) proto_err++;
                if (p_ar && (!ARVALID || ARADDR !== p_araddr)) proto_err++;
            end
            p_aw <= AWVALID && !AWREADY; p_awaddr <= AWADDR;
            p_w  <= WVALID && !WREADY;
            p_ar <= ARVALID && !ARREADY; p_araddr <= ARADDR;
        end
    end

    // ---------------- reference model ----------------
    logic [DW-1:0] exp_mem [4];

    function automatic logic [1:0] exp_resp(input logic [AW-1:0] a);
        if (force_en) return force_resp;
        return (a >= 4'd12) ? 2'b10 : 2'b00;
    endfunction

    task automatic model_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s);
        logic [DW-1:0] mask;
        mask = '0;
        for (int b = 0; b < SW; b++) if (s[b]) mask = mask | (32'hFF << (8 * b));
        exp_mem[a / 4] = (exp_mem[a / 4] & ~mask) | (d & mask);
    endtask

    task automatic model_clear();
        for (int i = 0; i < 4; i++) exp_mem[i] = '0;
    endtask

    function automatic logic [63:0] all_outputs();
        return {cmd_ready, rsp_valid, rsp_rdata, rsp_resp, rsp_timeout, AWVALID, WVALID,
                BREADY, ARVALID, RREADY, AWPROT, ARPROT, AWADDR, ARADDR, WSTRB};
    endfunction

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // ---------------- command driver ----------------
    task automatic issue(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s);
        int n = 0;
        cmd_valid = 1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
        while (!cmd_ready && n < 50) begin tick(); n++; end
        vectors++;
        if (cmd_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL accept: cmd_ready=%b after %0d cycles, required 1", cmd_ready, n);
        end
        tick();
        cmd_valid = 0; cmd_write = 1'($urandom); cmd_addr = AW'($urandom);
        cmd_wdata = $urandom; cmd_wstrb = SW'($urandom);
    endtask

    task automatic wait_rsp(output int lat);
        lat = 1;
        while (!rsp_valid && lat < 200) begin tick(); lat++; end
        vectors++;
        if (rsp_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL rsp_wait: rsp_valid=%b after %0d cycles, required 1", rsp_valid, lat);
        end
    endtask

    task automatic release_rsp(input int hold);
        repeat (hold) tick();
        rsp_ready = 1;
        tick();
        rsp_ready = 0;
    endtask

    task automatic do_txn(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic [SW-1:0] s, input int hold);
        int lat, exp_lat;
        logic [DW-1:0] er;
        logic [1:0] eresp;
        exp_lat = wr ? 3 + ((aw_dly > w_dly) ? aw_dly : w_dly) + b_dly : 3 + ar_dly + r_dly;
        er      = wr ? '0 : exp_mem[a / 4];
        eresp   = exp_resp(a);
        issue(wr, a, d, s);
        wait_rsp(lat);
        vectors++;
        if ({rsp_rdata, rsp_resp, rsp_timeout} !== {er, eresp, 1'b0}) begin
            miscompares++;
            $display("FAIL txn_payload wr=%0d addr=%h: got rdata=%h resp=%b tmo=%b, required rdata=%h resp=%b tmo=0",
                     wr, a, rsp_rdata, rsp_resp, rsp_timeout, er, eresp);
        end
        vectors++;
        if (lat !== exp_lat) begin
            miscompares++;
            $display("FAIL txn_latency wr=%0d: got %0d, required %0d", wr, lat, exp_lat);
        end
        if (wr) model_write(a, d, s);
        release_rsp(hold);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1; cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
        rsp_ready = 0;
        model_clear();
        #2 rst_n = 0;
        #1;
        vectors++;
        if (all_outputs() !== 64'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %h, required 0", all_outputs());
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        tick();
        vectors++;
        if ({cmd_ready, rsp_valid} !== 2'b10) begin
            miscompares++;
            $display("FAIL reset_release: cmd_ready,rsp_valid=%b, required 10", {cmd_ready, rsp_valid});
        end
    endtask

    task automatic test_write_basic();
        issue(1, 4'h0, 32'h0000_000A, 4'hF);
        vectors++;
        if ({AWVALID, WVALID, BREADY, AWADDR, WDATA, WSTRB} !== {1'b1, 1'b1, 1'b0, 4'h0, 32'hA, 4'hF}) begin
            miscompares++;
            $display("FAIL wr_cycle1: aw=%b w=%b b=%b addr=%h data=%h strb=%h, required 1 1 0 0 0000000a f",
                     AWVALID, WVALID, BREADY, AWADDR, WDATA, WSTRB);
        end
        tick();
        vectors++;
        if ({AWVALID, WVALID, BREADY, rsp_valid} !== 4'b0010) begin
            miscompares++;
            $display("FAIL wr_cycle2: aw,w,bready,rsp_valid=%b, required 0010", {AWVALID, WVALID, BREADY, rsp_valid});
        end
        tick();
        vectors++;
        if ({BREADY, rsp_valid, rsp_resp, rsp_rdata} !== {1'b0, 1'b1, 2'b00, 32'h0}) begin
            miscompares++;
            $display("FAIL wr_cycle3: bready=%b rsp_valid=%b resp=%b rdata=%h, required 0 1 00 0",
                     BREADY, rsp_valid, rsp_resp, rsp_rdata);
        end
        model_write(4'h0, 32'hA, 4'hF);
        release_rsp(0);
    endtask

    task automatic test_aw_stall();
        int c = 1, aw_hi = 0, w_hi = 0;
        aw_dly = 5;
        issue(1, 4'h8, 32'hCAFE_0008, 4'hF);
        while (!rsp_valid && c < 40) begin
            aw_hi += int'(AWVALID); w_hi += int'(WVALID);
            tick(); c++;
        end
        vectors++;
        if ({aw_hi, w_hi, c} !== {32'd6, 32'd1, 32'd8}) begin
            miscompares++;
            $display("FAIL aw_stall: awvalid cycles=%0d wvalid cycles=%0d rsp at %0d, required 6 1 8", aw_hi, w_hi, c);
        end
        vectors++;
        if ({rsp_resp, rsp_rdata} !== {2'b00, 32'h0}) begin
            miscompares++;
            $display("FAIL aw_stall_rsp: resp=%b rdata=%h, required 00 0", rsp_resp, rsp_rdata);
        end
        model_write(4'h8, 32'hCAFE_0008, 4'hF);
        release_rsp(0);
        vectors++;
        if (rsp_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL aw_stall_single: rsp_valid=%b after handshake, required 0", rsp_valid);
        end
        aw_dly = 0;
    endtask

    task automatic test_read_wait();
        int c = 1, rr_hi = 0, ar_hi = 0, both = 0;
        do_txn(1, 4'h4, 32'h0000_1234, 4'hF, 0);
        force_en = 1; force_resp = 2'b10; r_dly = 3;
        issue(0, 4'h4, 32'h0, 4'h0);
        while (!rsp_valid && c < 40) begin
            rr_hi += int'(RREADY); ar_hi += int'(ARVALID); both += int'(RREADY && ARVALID);
            tick(); c++;
        end
        vectors++;
        if ({rr_hi, ar_hi, both, c} !== {32'd4, 32'd1, 32'd0, 32'd6}) begin
            miscompares++;
            $display("FAIL rd_wait_timing: rready=%0d arvalid=%0d overlap=%0d rsp at %0d, required 4 1 0 6",
                     rr_hi, ar_hi, both, c);
        end
        vectors++;
        if ({rsp_rdata, rsp_resp, RREADY} !== {32'h0000_1234, 2'b10, 1'b0}) begin
            miscompares++;
            $display("FAIL rd_wait_rsp: rdata=%h resp=%b rready=%b, required 00001234 10 0", rsp_rdata, rsp_resp, RREADY);
        end
        release_rsp(0);
        force_en = 0; r_dly = 0;
    endtask

    task automatic test_backpressure();
        int lat;
        logic [DW-1:0] cap_d;
        logic [1:0] cap_r;
        logic [DW-1:0] wd;
        wd = $urandom;
        issue(1, 4'hC, wd, 4'h5);
        wait_rsp(lat);
        cap_d = rsp_rdata; cap_r = rsp_resp;
        model_write(4'hC, wd, 4'h5);
        cmd_valid = 1; cmd_write = 0; cmd_addr = 4'hC;
        for (int i = 0; i < 10; i++) begin
            tick();
            vectors++;
            if ({rsp_valid, rsp_rdata, rsp_resp, cmd_ready, AWVALID, WVALID, ARVALID, BREADY, RREADY}
                !== {1'b1, cap_d, cap_r, 6'b0}) begin
                miscompares++;
                $display("FAIL hold_cycle%0d: rsp_valid=%b rdata=%h resp=%b cmd_ready=%b bus=%b, required 1 %h %b 0 00000",
                         i, rsp_valid, rsp_rdata, rsp_resp, cmd_ready,
                         {AWVALID, WVALID, ARVALID, BREADY, RREADY}, cap_d, cap_r);
            end
        end
        rsp_ready = 1;
        tick();
        rsp_ready = 0;
        vectors++;
        if ({cmd_ready, rsp_valid} !== 2'b10) begin
            miscompares++;
            $display("FAIL b2b_ready: cmd_ready,rsp_valid=%b, required 10", {cmd_ready, rsp_valid});
        end
        tick();
        cmd_valid = 0;
        vectors++;
        if ({ARVALID, ARADDR} !== {1'b1, 4'hC}) begin
            miscompares++;
            $display("FAIL b2b_issue: arvalid=%b araddr=%h, required 1 c", ARVALID, ARADDR);
        end
        wait_rsp(lat);
        vectors++;
        if ({rsp_rdata, rsp_resp, lat} !== {exp_mem[3], 2'b10, 32'd3}) begin
            miscompares++;
            $display("FAIL b2b_rsp: rdata=%h resp=%b lat=%0d, required %h 10 3", rsp_rdata, rsp_resp, lat, exp_mem[3]);
        end
        release_rsp(0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            aw_dly = $urandom_range(0, 4); w_dly = $urandom_range(0, 4); b_dly = $urandom_range(0, 3);
            ar_dly = $urandom_range(0, 4); r_dly = $urandom_range(0, 3);
            do_txn(1'($urandom), AW'($urandom), $urandom, SW'($urandom), $urandom_range(0, 3));
        end
        for (int i = 0; i < 4; i++) begin
            aw_dly = 0; w_dly = 0; b_dly = 0; ar_dly = 0; r_dly = 0;
            do_txn(0, AW'(4 * i), 32'h0, 4'h0, 0);
        end
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        ar_dly = 20;
        issue(0, 4'h4, 32'h0, 4'h0);
        tick();
        vectors++;
        if (ARVALID !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_arvalid: arvalid=%b before reset, required 1", ARVALID);
        end
        #2 rst_n = 0;
        #1;
        vectors++;
        if (all_outputs() !== 64'd0) begin
            miscompares++;
            $display("FAIL mid_reset_outputs: got %h, required 0", all_outputs());
        end
        model_clear();
        ar_dly = 0;
        tick();
        rst_n = 1;
        tick();
        vectors++;
        if ({cmd_ready, rsp_valid, ARVALID} !== 3'b100) begin
            miscompares++;
            $display("FAIL mid_release: cmd_ready,rsp_valid,arvalid=%b, required 100", {cmd_ready, rsp_valid, ARVALID});
        end
        repeat (5) begin tick(); seen += int'(rsp_valid || ARVALID || AWVALID); end
        vectors++;
        if (seen !== 0) begin
            miscompares++;
            $display("FAIL mid_stale: %0d cycles of stale activity, required 0", seen);
        end
    endtask

`ifdef AXI_MASTER_TIMEOUT_EN
    task automatic test_timeout();
        int c = 1;
        logic last_bready = 0;
        mon_en = 0; b_never = 1;
        issue(1, 4'h0, 32'h1, 4'hF);
        while (!rsp_valid && c < 100) begin last_bready = BREADY; tick(); c++; end
        vectors++;
        if ({c, last_bready, BREADY, AWVALID, WVALID} !== {32'd16, 1'b1, 3'b000}) begin
            miscompares++;
            $display("FAIL timeout_timing: rsp at %0d bready before=%b now=%b aw=%b w=%b, required 16 1 0 0 0",
                     c, last_bready, BREADY, AWVALID, WVALID);
        end
        vectors++;
        if ({rsp_resp, rsp_timeout, rsp_rdata} !== {2'b11, 1'b1, 32'h0}) begin
            miscompares++;
            $display("FAIL timeout_rsp: resp=%b tmo=%b rdata=%h, required 11 1 0", rsp_resp, rsp_timeout, rsp_rdata);
        end
        release_rsp(0);
        b_never = 0;
        rst_n = 0; model_clear();
        tick(); rst_n = 1; tick();
        mon_en = 1;
    endtask
`endif

    task automatic test_protocol();
        vectors++;
        if (proto_err !== 0) begin
            miscompares++;
            $display("FAIL valid_stability: %0d violations, required 0", proto_err);
        end
    endtask

    initial begin
        test_reset();
        test_write_basic();
        test_aw_stall();
        test_read_wait();
        test_backpressure();
        test_random();
        test_reset_mid();
`ifdef AXI_MASTER_TIMEOUT_EN
        test_timeout();
`endif
        test_protocol();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/axi_lite_cmd_master.md
Name: axi_lite_cmd_master

Overview:
- PL-side AXI4-Lite single-beat master sitting directly upstream of the LED/7-seg/IRQ AXI4-Lite slave.
- Converts a simple valid/ready command stream into AXI4-Lite read or write transactions, then returns one response per command.
- Used for PL-local self-test sequencers and for bring-up without the PS.
- One outstanding transaction at a time; no bursts.

Parameters:
- ADDR_WIDTH, 4, AXI address width (16-byte slave space).
- DATA_WIDTH, 32, AXI data width; strobe width is DATA_WIDTH/8.
- TIMEOUT_CYCLES, 1024, bus-hang limit in clk cycles. Used only with AXI_MASTER_TIMEOUT_EN; must be ≥2.

Ports:
- clk  in  1  single clock, shared with the slave's S_AXI_ACLK.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted this cycle when high together with cmd_valid.
- cmd_write  in  1  1=write, 0=read.
- cmd_addr  in  ADDR_WIDTH  byte address.
- cmd_wdata  in  DATA_WIDTH  write data.
- cmd_wstrb  in  DATA_WIDTH/8  write strobes.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed.
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes.
- rsp_resp  out  2  BRESP or RRESP, or 2'b11 on timeout.
- rsp_timeout  out  1  transaction aborted by timeout.
- M_AXI_AWADDR/AWPROT/AWVALID out, AWREADY in: AW channel; AWPROT=3'b000.
- M_AXI_WDATA/WSTRB/WVALID out, WREADY in: W channel.
- M_AXI_BRESP/BVALID in, BREADY out: B channel.
- M_AXI_ARADDR/ARPROT/ARVALID out, ARREADY in: AR channel; ARPROT=3'b000.
- M_AXI_RDATA/RRESP/RVALID in, RREADY out: R channel.

Behaviour:
- Reset values: all VALID/READY outputs 0, all data/address outputs 0, rsp_valid 0, rsp_timeout 0, state IDLE. Reset mid-transaction aborts immediately; no response is issued.
- FSM states: IDLE, WR_AW_W, WR_B, RD_AR, RD_R, RSP.
- IDLE:
  - cmd_ready=1 (registered output, only in IDLE).
  - On handshake, latch the command and go to WR_AW_W (write) or RD_AR (read).
  - AWVALID+WVALID, or ARVALID, rise the cycle after acceptance.
- WR_AW_W:
  - AWVALID and WVALID are driven independently.
  - Each drops the cycle after its own handshake, tracked by aw_done and w_done flags. Either order, or the same cycle, is legal.
  - When both are done, go to WR_B with BREADY=1.
- WR_B: on BVALID, capture BRESP, set rsp_rdata=0, BREADY->0, go to RSP.
- RD_AR: ARVALID high until ARREADY, then go to RD_R with RREADY=1.
- RD_R: on RVALID, capture RDATA/RRESP, RREADY->0, go to RSP.
- RSP:
  - rsp_valid=1 and payload held stable until rsp_ready.
  - Then return to IDLE; cmd_ready rises the following cycle.
  - Minimum command-to-command spacing is therefore 1 cycle after the response handshake.
- VALID signals never drop before their handshake (AXI rule), except on timeout abort.
- Command fields are ignored outside IDLE; outputs always come from the latched copy.
- Latency with a zero-wait slave:
  - write: accept@0, AW/W@1, B@2, rsp_valid@3.
  - read: accept@0, AR@1, R@2, rsp_valid@3.

Optional Feature:
- Macro: AXI_MASTER_TIMEOUT_EN.
- With the macro:
  - A cycle counter clears on command accept and increments in every bus state (not RSP).
  - Reaching TIMEOUT_CYCLES-1 forces all M_AXI VALID/READY outputs to 0 and moves to RSP with rsp_resp=2'b11, rsp_timeout=1, rsp_rdata=0.
  - A late slave handshake in the same cycle as the timeout loses; the timeout wins.
  - This is a deliberate protocol deviation for hung-bus recovery only.
- Without the macro: no counter; rsp_timeout tied 0; the block waits indefinitely.

Decomposition:
- Shared package axi_lite_pkg:
  - AXI_RESP_OKAY/EXOKAY/SLVERR/DECERR constants.
  - FSM state encoding typedef.
  - A default-PROT constant.
- No sub-module needed. The timeout counter is inline, under the macro.

Test Plan:
- Write addr 0x0, data 0x0000_000A, strb 0xF, slave zero-wait -> AW/W at cycle 1, BREADY at 2, rsp_valid at 3 with rsp_resp=00, rsp_rdata=0.
- Write with the slave holding AWREADY low for 5 cycles while WREADY is immediate -> WVALID drops after 1 cycle, AWVALID holds 6 cycles, then a single response with OKAY.
- Read addr 0x4, slave returns RDATA 0x0000_1234 RRESP=10 after 3 wait cycles -> rsp_rdata=0x0000_1234, rsp_resp=10; RREADY high only in RD_R.
- rsp_ready held low 10 cycles -> rsp payload stable, cmd_ready stays 0, no new AXI activity; then back-to-back command accepted 1 cycle after release.
- rst_n asserted while ARVALID is high -> all outputs 0 asynchronously; after release, state IDLE, cmd_ready=1, no stale response.
- With AXI_MASTER_TIMEOUT_EN, TIMEOUT_CYCLES=16, slave never asserts BVALID -> BREADY drops and rsp_valid asserts 16 cycles after accept with rsp_resp=11, rsp_timeout=1.
